// File: rtl/readout_sequencer.sv
// Sequences an event readout across NCH digitizer channels in ascending order,
// emitting one header word and how_many data words per enabled channel.
module readout_sequencer #(
    parameter int NCH    = 4,
    parameter int CHW    = 2,
    parameter int SIZE   = 12,
    parameter int WIDTH  = 12,
    parameter int RD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NCH-1:0]       ch_enable,
    input  logic [SIZE-1:0]      how_many,
    output logic                 busy,
    output logic                 done,
    output logic [NCH-1:0]       ch_read_request,
    input  logic [NCH*WIDTH-1:0] ch_data,
    output logic                 out_valid,
    output logic                 out_header,
    output logic [CHW-1:0]       out_chan,
    output logic [WIDTH-1:0]     out_data
);
    localparam int PW = $clog2(NCH + 1);

    typedef enum logic [2:0] {IDLE, SELECT, HEADER, READ, DRAIN, FINISH} state_t;

    state_t            state;
    logic [NCH-1:0]    mask;
    logic [SIZE-1:0]   count;
    logic [SIZE-1:0]   remaining;
    logic [PW-1:0]     ptr;
    logic [CHW-1:0]    cur;
    logic [RD_LAT-1:0] pipe;

    logic              found;
    logic [CHW-1:0]    next_ch;
    logic [PW-1:0]     next_ptr;
    logic [WIDTH-1:0]  cur_data;

    // Descending scan so the lowest enabled channel at or above ptr wins.
    always_comb begin
        found    = 1'b0;
        next_ch  = '0;
        next_ptr = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i] && (PW'(i) >= ptr)) begin
                found    = 1'b1;
                next_ch  = CHW'(i);
                next_ptr = PW'(i + 1);
            end
        end
    end

    always_comb begin
        cur_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (CHW'(i) == cur) begin
                cur_data = ch_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            mask            <= '0;
            count           <= '0;
            remaining       <= '0;
            ptr             <= '0;
            cur             <= '0;
            pipe            <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            ch_read_request <= '0;
            out_valid       <= 1'b0;
            out_header      <= 1'b0;
            out_chan        <= '0;
            out_data        <= '0;
        end else begin
            done       <= 1'b0;
            out_valid  <= 1'b0;
            out_header <= 1'b0;
            out_chan   <= '0;
            out_data   <= '0;

            // Each request cycle travels RD_LAT stages, then the sample is registered out.
            pipe <= (pipe << 1) | RD_LAT'(|ch_read_request);
            if (pipe[RD_LAT-1]) begin
                out_valid <= 1'b1;
                out_chan  <= cur;
                out_data  <= cur_data;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        mask  <= ch_enable;
                        count <= how_many;
                        ptr   <= '0;
                        busy  <= 1'b1;
                        state <= SELECT;
                    end
                end
                SELECT: begin
                    if (!found || count == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        cur   <= next_ch;
                        ptr   <= next_ptr;
                        state <= HEADER;
                    end
                end
                HEADER: begin
                    out_valid       <= 1'b1;
                    out_header      <= 1'b1;
                    out_chan        <= cur;
                    out_data        <= WIDTH'(count);
                    ch_read_request <= NCH'(1) << cur;
                    remaining       <= count;
                    state           <= READ;
                end
                READ: begin
                    if (remaining == SIZE'(1)) begin
                        ch_read_request <= '0;
                        state           <= DRAIN;
                    end else begin
                        remaining <= remaining - SIZE'(1);
                    end
                end
                DRAIN: begin
                    if (pipe == '0) begin
                        state <= SELECT;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_readout_sequencer.sv
// Randomized bench for readout_sequencer: an event-level model predicts the word
// stream and request runs, and a negedge monitor checks the DUT against it.
module tb_readout_sequencer;
    localparam int NCH    = 4;
    localparam int CHW    = 2;
    localparam int SIZE   = 12;
    localparam int WIDTH  = 12;
    localparam int RD_LAT = 2;

    typedef struct {
        bit hdr;
        int ch;
        int n;
        bit first;
    } word_t;

    typedef struct {
        int ch;
        int n;
    } run_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic [NCH-1:0]       ch_enable = '0;
    logic [SIZE-1:0]      how_many = '0;
    logic                 busy;
    logic                 done;
    logic [NCH-1:0]       ch_read_request;
    logic [NCH*WIDTH-1:0] ch_data = '0;
    logic                 out_valid;
    logic                 out_header;
    logic [CHW-1:0]       out_chan;
    logic [WIDTH-1:0]     out_data;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int data_mode = 0;
    int done_cnt = 0;
    int run_len = 0;
    int run_n = 0;
    int run_ch = 0;
    bit prev_valid = 1'b0;

    word_t exp_words[$];
    run_t  exp_req[$];
    logic [NCH*WIDTH-1:0] hist [64];
    logic [NCH-1:0]       req_hist [64];

    readout_sequencer #(
        .NCH(NCH), .CHW(CHW), .SIZE(SIZE), .WIDTH(WIDTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .ch_enable(ch_enable),
        .how_many(how_many),
        .busy(busy),
        .done(done),
        .ch_read_request(ch_read_request),
        .ch_data(ch_data),
        .out_valid(out_valid),
        .out_header(out_header),
        .out_chan(out_chan),
        .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Channel data changes every cycle: random, constant 0x100+i, or a tagged cycle counter.
    always @(posedge clk) begin
        #1;
        cyc++;
        for (int i = 0; i < NCH; i++) begin
            case (data_mode)
                1:       ch_data[i*WIDTH +: WIDTH] = WIDTH'(12'h100 + i);
                2:       ch_data[i*WIDTH +: WIDTH] = WIDTH'(cyc * 16 + i);
                default: ch_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            endcase
        end
    end

    // Monitor: a data word must carry the sample present RD_LAT cycles after its
    // request, and appear RD_LAT+1 cycles after that request.
    always @(negedge clk) begin
        word_t w;
        run_t  r;
        int    rch;
        hist[cyc % 64]     = ch_data;
        req_hist[cyc % 64] = ch_read_request;
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (done) begin
                done_cnt++;
                checkOutput("busy_at_done", busy, 0);
            end
            if (ch_read_request != '0) begin
                checkOutput("req_onehot", $onehot(ch_read_request), 1);
                rch = 0;
                for (int i = 0; i < NCH; i++) if (ch_read_request[i]) rch = i;
                if (run_len == 0) begin
                    if (exp_req.size() == 0) begin
                        checkOutput("req_unexpected", rch, NCH);
                        run_n = 0;
                    end else begin
                        r = exp_req.pop_front();
                        checkOutput("req_chan", rch, r.ch);
                        run_n = r.n;
                    end
                    run_ch  = rch;
                    run_len = 1;
                end else begin
                    checkOutput("req_steady", rch, run_ch);
                    run_len++;
                end
            end else if (run_len != 0) begin
                checkOutput("req_len", run_len, run_n);
                run_len = 0;
            end
            if (out_valid) begin
                if (exp_words.size() == 0) begin
                    checkOutput("word_extra", out_valid, 0);
                end else begin
                    w = exp_words.pop_front();
                    checkOutput("hdr_flag", out_header, w.hdr);
                    checkOutput("chan", out_chan, w.ch);
                    if (w.hdr) begin
                        checkOutput("hdr_data", out_data, w.n);
                    end else begin
                        checkOutput("data", out_data, hist[(cyc - 1) % 64][w.ch*WIDTH +: WIDTH]);
                        checkOutput("latency", req_hist[(cyc - RD_LAT - 1) % 64][w.ch], 1);
                        if (!w.first) checkOutput("contig", prev_valid, 1);
                    end
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic buildExpect(input logic [NCH-1:0] m, input int n);
        for (int c = 0; c < NCH; c++) begin
            if (m[c] && n > 0) begin
                exp_words.push_back(word_t'{1'b1, c, n, 1'b0});
                for (int k = 0; k < n; k++) exp_words.push_back(word_t'{1'b0, c, n, k == 0});
                exp_req.push_back(run_t'{c, n});
            end
        end
    endtask

    task automatic applyStimulus(input logic [NCH-1:0] m, input int n, input bit glitch,
                                 output int waited);
        int d0;
        int budget;
        buildExpect(m, n);
        d0     = done_cnt;
        budget = NCH * (n + RD_LAT + 8) + 20;
        @(posedge clk); #2;
        start     = 1'b1;
        ch_enable = m;
        how_many  = SIZE'(n);
        @(posedge clk); #2;
        start     = 1'b0;
        ch_enable = NCH'($urandom);
        how_many  = SIZE'($urandom);
        checkOutput("busy_rise", busy, 1);
        waited = 0;
        while (done_cnt == d0 && waited < budget) begin
            @(posedge clk); #2;
            waited++;
            if (glitch && waited == 6) begin
                start     = 1'b1;
                how_many  = SIZE'(7);
                ch_enable = '1;
            end else begin
                start = 1'b0;
            end
        end
        checkOutput("done_seen", done_cnt != d0, 1);
        repeat (4) @(posedge clk);
        #2;
        checkOutput("done_once", done_cnt - d0, 1);
        checkOutput("words_left", exp_words.size(), 0);
        checkOutput("runs_left", exp_req.size(), 0);
        checkOutput("busy_end", busy, 0);
        exp_words.delete();
        exp_req.delete();
    endtask

    initial begin
        int waited;
        int w;
        int d0;

        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_req", ch_read_request, 0);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_data", out_data, 0);
        reset = 1'b0;

        $display("[TB] two-channel constant-data event");
        data_mode = 1;
        applyStimulus(4'b0101, 3, 1'b0, waited);

        $display("[TB] latency event on ch1 with counter data");
        data_mode = 2;
        applyStimulus(4'b0010, 5, 1'b0, waited);

        $display("[TB] empty events");
        data_mode = 0;
        applyStimulus(4'b0000, 3, 1'b0, waited);
        checkOutput("empty_mask_fast", waited <= 3, 1);
        applyStimulus(4'b1111, 0, 1'b0, waited);
        checkOutput("zero_count_fast", waited <= 3, 1);

        $display("[TB] start ignored while busy");
        applyStimulus(4'b0011, 10, 1'b1, waited);

        $display("[TB] reset during the second request cycle");
        buildExpect(4'b0001, 6);
        @(posedge clk); #2;
        start     = 1'b1;
        ch_enable = 4'b0001;
        how_many  = SIZE'(6);
        @(posedge clk); #2;
        start = 1'b0;
        w = 0;
        while (ch_read_request == '0 && w < 20) begin
            @(posedge clk); #2;
            w++;
        end
        checkOutput("rst_req_seen", ch_read_request, 4'b0001);
        @(posedge clk); #2;
        reset = 1'b1;
        d0 = done_cnt;
        @(posedge clk); #2;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_req", ch_read_request, 0);
        checkOutput("abort_valid", out_valid, 0);
        checkOutput("abort_header", out_header, 0);
        checkOutput("abort_chan", out_chan, 0);
        checkOutput("abort_data", out_data, 0);
        @(posedge clk); #2;
        reset = 1'b0;
        exp_words.delete();
        exp_req.delete();
        run_len = 0;
        repeat (8) @(posedge clk);
        #2;
        checkOutput("abort_no_done", done_cnt - d0, 0);
        applyStimulus(4'b0101, 4, 1'b0, waited);

        $display("[TB] randomized events");
        for (int e = 0; e < 14; e++) begin
            data_mode = $urandom_range(0, 2);
            applyStimulus(NCH'($urandom), $urandom_range(0, 12), 1'b0, waited);
        end

        $display("[TB] maximum count on ch3");
        data_mode = 0;
        applyStimulus(4'b1000, 4095, 1'b0, waited);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
